// File: rtl/cpu_pkg.sv
// Shared opcode constants, sequencer states and control bundles
// for the hard-wired control unit.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2,
    S_E1, S_E2, S_E3, S_E4, S_E5,
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_R, C_IMM, C_NEG, C_LDI,
    C_LD, C_ST, C_BR, C_JR, C_JAL,
    C_MFHL, C_IN, C_OUT, C_MD, C_HALT
  } cls_t;

  typedef struct packed {
    logic ADD;
    logic SUB;
    logic MUL;
    logic DIV;
    logic SHR;
    logic SHL;
    logic ROR;
    logic ROL;
    logic AND;
    logic OR;
    logic NEGATE;
    logic NOT;
  } alu_t;

  typedef struct packed {
    logic PCout;
    logic MDRout;
    logic RZout;
    logic HILOout;
    logic INPUTout;
    logic Cout;
    logic BAout;
    logic Rout;
    logic Gra;
    logic Grb;
    logic Grc;
    logic PCin;
    logic IRin;
    logic RYin;
    logic RZin;
    logic MARin;
    logic MDRin;
    logic HILOin;
    logic CONin;
    logic OUTPUTin;
    logic Rin;
    logic Read;
    logic Write;
    logic IncPC;
    alu_t alu;
  } ctl_t;

  // Number of execute steps after fetch for each class.
  function automatic logic [2:0] e_count(cls_t c);
    case (c)
      C_R, C_IMM, C_LDI, C_MD: e_count = 3'd3;
      C_NEG, C_JAL:            e_count = 3'd2;
      C_LD, C_ST:              e_count = 3'd5;
      C_BR:                    e_count = 3'd4;
      C_JR, C_MFHL:            e_count = 3'd1;
      C_IN, C_OUT:             e_count = 3'd1;
      default:                 e_count = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/opcode_class_decode.sv
// Opcode to {instruction class, ALU one-hot}.
// mul/div decode only when CU_MULDIV_EN is defined.
module opcode_class_decode
  import cpu_pkg::*;
(
  input  logic [4:0]  op_i,
  output logic [3:0]  cls_o,
  output logic [11:0] alu_o
);

  cls_t cls;
  alu_t alu;

  always_comb begin
    cls = C_NOP;
    alu = '0;
    case (op_i)
      OP_LD:   cls = C_LD;
      OP_LDI:  cls = C_LDI;
      OP_ST:   cls = C_ST;
      OP_ADD:  begin cls = C_R; alu.ADD = 1'b1; end
      OP_SUB:  begin cls = C_R; alu.SUB = 1'b1; end
      OP_SHR:  begin cls = C_R; alu.SHR = 1'b1; end
      OP_SHL:  begin cls = C_R; alu.SHL = 1'b1; end
      OP_ROR:  begin cls = C_R; alu.ROR = 1'b1; end
      OP_ROL:  begin cls = C_R; alu.ROL = 1'b1; end
      OP_AND:  begin cls = C_R; alu.AND = 1'b1; end
      OP_OR:   begin cls = C_R; alu.OR = 1'b1; end
      OP_ADDI: begin cls = C_IMM; alu.ADD = 1'b1; end
      OP_ANDI: begin cls = C_IMM; alu.AND = 1'b1; end
      OP_ORI:  begin cls = C_IMM; alu.OR = 1'b1; end
`ifdef CU_MULDIV_EN
      OP_MUL:  begin cls = C_MD; alu.MUL = 1'b1; end
      OP_DIV:  begin cls = C_MD; alu.DIV = 1'b1; end
`else
      OP_MUL, OP_DIV: cls = C_NOP;
`endif
      OP_NEG:  begin cls = C_NEG; alu.NEGATE = 1'b1; end
      OP_NOT:  begin cls = C_NEG; alu.NOT = 1'b1; end
      OP_BR:   cls = C_BR;
      OP_JR:   cls = C_JR;
      OP_JAL:  cls = C_JAL;
      OP_IN:   cls = C_IN;
      OP_OUT:  cls = C_OUT;
      OP_MFHI, OP_MFLO: cls = C_MFHL;
      OP_HALT: cls = C_HALT;
      default: cls = C_NOP;
    endcase
  end

  assign cls_o = cls;
  assign alu_o = alu;

endmodule

// File: rtl/control_unit.sv
// Hard-wired fetch/execute sequencer driving the datapath strobes.
// Define CU_MULDIV_EN to decode mul/div; otherwise they run as nop.
module control_unit
  import cpu_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [BITS-1:0] IRVal,
  input  logic            CON,
  input  logic            Stop,
  output logic            PCout,
  output logic            MDRout,
  output logic            RZout,
  output logic            HILOout,
  output logic            INPUTout,
  output logic            Cout,
  output logic            BAout,
  output logic            Rout,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            PCin,
  output logic            IRin,
  output logic            RYin,
  output logic            RZin,
  output logic            MARin,
  output logic            MDRin,
  output logic            HILOin,
  output logic            CONin,
  output logic            OUTPUTin,
  output logic            Rin,
  output logic            Read,
  output logic            Write,
  output logic            IncPC,
  output logic            ADD,
  output logic            SUB,
  output logic            MUL,
  output logic            DIV,
  output logic            SHR,
  output logic            SHL,
  output logic            ROR,
  output logic            ROL,
  output logic            AND,
  output logic            OR,
  output logic            NEGATE,
  output logic            NOT,
  output logic            Run
);

  state_t      state_q;
  logic [4:0]  op_q;
  logic [4:0]  dec_op;
  logic [3:0]  cls_raw;
  logic [11:0] alu_raw;
  cls_t        cls;
  alu_t        alu;
  logic [2:0]  ecnt;
  logic [2:0]  estep;
  logic        last;
  ctl_t        c;
  logic        unused_ir;

  assign unused_ir = ^IRVal[BITS-6:0];

  // During T2 the class comes straight from IR; afterwards from op_q.
  assign dec_op = (state_q == S_T2) ? IRVal[BITS-1:BITS-5] : op_q;

  opcode_class_decode u_dec (
    .op_i  (dec_op),
    .cls_o (cls_raw),
    .alu_o (alu_raw)
  );

  assign cls  = cls_t'(cls_raw);
  assign alu  = alu_raw;
  assign ecnt = e_count(cls);

  always_comb begin
    estep = 3'd0;
    case (state_q)
      S_E1:    estep = 3'd1;
      S_E2:    estep = 3'd2;
      S_E3:    estep = 3'd3;
      S_E4:    estep = 3'd4;
      S_E5:    estep = 3'd5;
      default: estep = 3'd0;
    endcase
  end

  assign last = (estep != 3'd0) && (estep == ecnt);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_RST;
      op_q    <= OP_NOP;
    end else begin
      case (state_q)
        S_RST: state_q <= S_T0;
        S_T0:  state_q <= S_T1;
        S_T1:  state_q <= S_T2;
        S_T2: begin
          op_q <= IRVal[BITS-1:BITS-5];
          if (cls == C_HALT)
            state_q <= S_HALT;
          else if (ecnt == 3'd0)
            state_q <= Stop ? S_HALT : S_T0;
          else
            state_q <= S_E1;
        end
        S_E1, S_E2, S_E3, S_E4, S_E5: begin
          if (last)
            state_q <= Stop ? S_HALT : S_T0;
          else
            state_q <= state_t'(state_q + 4'd1);
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_RST;
      endcase
    end
  end

  always_comb begin
    c = '0;
    case (state_q)
      S_T0: begin
        c.PCout = 1'b1; c.MARin = 1'b1;
        c.IncPC = 1'b1; c.RZin = 1'b1;
      end
      S_T1: begin
        c.RZout = 1'b1; c.PCin = 1'b1;
        c.Read = 1'b1; c.MDRin = 1'b1;
      end
      S_T2: begin c.MDRout = 1'b1; c.IRin = 1'b1; end
      S_E1: case (cls)
        C_R, C_IMM: begin
          c.Grb = 1'b1; c.Rout = 1'b1; c.RYin = 1'b1;
        end
        C_NEG: begin
          c.Grb = 1'b1; c.Rout = 1'b1;
          c.alu = alu; c.RZin = 1'b1;
        end
        C_LDI, C_LD, C_ST: begin
          c.Grb = 1'b1; c.BAout = 1'b1; c.RYin = 1'b1;
        end
        C_BR: begin
          c.Gra = 1'b1; c.Rout = 1'b1; c.CONin = 1'b1;
        end
        C_JR: begin
          c.Gra = 1'b1; c.Rout = 1'b1; c.PCin = 1'b1;
        end
        C_JAL: begin
          c.PCout = 1'b1; c.Grb = 1'b1; c.Rin = 1'b1;
        end
        C_MFHL: begin
          c.HILOout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1;
        end
        C_IN: begin
          c.INPUTout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1;
        end
        C_OUT: begin
          c.Gra = 1'b1; c.Rout = 1'b1; c.OUTPUTin = 1'b1;
        end
        C_MD: begin
          c.Gra = 1'b1; c.Rout = 1'b1; c.RYin = 1'b1;
        end
        default: ;
      endcase
      S_E2: case (cls)
        C_R: begin
          c.Grc = 1'b1; c.Rout = 1'b1;
          c.alu = alu; c.RZin = 1'b1;
        end
        C_IMM: begin
          c.Cout = 1'b1; c.alu = alu; c.RZin = 1'b1;
        end
        C_NEG: begin
          c.RZout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1;
        end
        C_LDI, C_LD, C_ST: begin
          c.Cout = 1'b1; c.alu.ADD = 1'b1; c.RZin = 1'b1;
        end
        C_BR: begin c.PCout = 1'b1; c.RYin = 1'b1; end
        C_JAL: begin
          c.Gra = 1'b1; c.Rout = 1'b1; c.PCin = 1'b1;
        end
        C_MD: begin
          c.Grb = 1'b1; c.Rout = 1'b1;
          c.alu = alu; c.RZin = 1'b1;
        end
        default: ;
      endcase
      S_E3: case (cls)
        C_R, C_IMM, C_LDI: begin
          c.RZout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1;
        end
        C_LD, C_ST: begin c.RZout = 1'b1; c.MARin = 1'b1; end
        C_BR: begin
          c.Cout = 1'b1; c.alu.ADD = 1'b1; c.RZin = 1'b1;
        end
        C_MD: begin c.RZout = 1'b1; c.HILOin = 1'b1; end
        default: ;
      endcase
      S_E4: case (cls)
        C_LD: begin c.Read = 1'b1; c.MDRin = 1'b1; end
        C_ST: begin
          c.Gra = 1'b1; c.Rout = 1'b1; c.MDRin = 1'b1;
        end
        C_BR: begin c.RZout = 1'b1; c.PCin = CON; end
        default: ;
      endcase
      S_E5: case (cls)
        C_LD: begin
          c.MDRout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1;
        end
        C_ST: c.Write = 1'b1;
        default: ;
      endcase
      default: ;
    endcase
  end

  assign {PCout, MDRout, RZout, HILOout, INPUTout, Cout,
          BAout, Rout, Gra, Grb, Grc, PCin, IRin, RYin,
          RZin, MARin, MDRin, HILOin, CONin, OUTPUTin,
          Rin, Read, Write, IncPC,
          ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL,
          AND, OR, NEGATE, NOT} = c;

  assign Run = (state_q != S_RST) && (state_q != S_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Randomised bench for control_unit: expected strobes come from
// per-opcode step tables written as lists of strobe names.
module tb_control_unit;

  logic clk = 1'b0;
  logic reset, CON, Stop;
  logic [31:0] IRVal;
  logic PCout, MDRout, RZout, HILOout, INPUTout, Cout, BAout;
  logic Rout, Gra, Grb, Grc, PCin, IRin, RYin, RZin, MARin;
  logic MDRin, HILOin, CONin, OUTPUTin, Rin, Read, Write, IncPC;
  logic ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL;
  logic AND, OR, NEGATE, NOT, Run;

  logic [36:0] act;
  int n_chk = 0;
  int n_err = 0;
  int idx[string];

  string nm[37] = '{"PCout", "MDRout", "RZout", "HILOout",
    "INPUTout", "Cout", "BAout", "Rout", "Gra", "Grb", "Grc",
    "PCin", "IRin", "RYin", "RZin", "MARin", "MDRin", "HILOin",
    "CONin", "OUTPUTin", "Rin", "Read", "Write", "IncPC",
    "ADD", "SUB", "MUL", "DIV", "SHR", "SHL", "ROR", "ROL",
    "AND", "OR", "NEGATE", "NOT", "Run"};

  control_unit #(.BITS(32)) dut (
    .clk(clk), .reset(reset), .IRVal(IRVal), .CON(CON),
    .Stop(Stop),
    .PCout(PCout), .MDRout(MDRout), .RZout(RZout),
    .HILOout(HILOout), .INPUTout(INPUTout), .Cout(Cout),
    .BAout(BAout), .Rout(Rout), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .PCin(PCin), .IRin(IRin), .RYin(RYin),
    .RZin(RZin), .MARin(MARin), .MDRin(MDRin),
    .HILOin(HILOin), .CONin(CONin), .OUTPUTin(OUTPUTin),
    .Rin(Rin), .Read(Read), .Write(Write), .IncPC(IncPC),
    .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR),
    .SHL(SHL), .ROR(ROR), .ROL(ROL), .AND(AND), .OR(OR),
    .NEGATE(NEGATE), .NOT(NOT), .Run(Run)
  );

  assign act = {PCout, MDRout, RZout, HILOout, INPUTout, Cout,
    BAout, Rout, Gra, Grb, Grc, PCin, IRin, RYin, RZin, MARin,
    MDRin, HILOin, CONin, OUTPUTin, Rin, Read, Write, IncPC,
    ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE,
    NOT, Run};

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [36:0] got,
                     input logic [36:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [36:0] bitof(input string n);
    logic [36:0] v = '0;
    v[36 - idx[n]] = 1'b1;
    return v;
  endfunction

  function automatic logic [36:0] to_vec(input string s);
    logic [36:0] v = '0;
    int st = 0;
    for (int i = 0; i <= s.len(); i++) begin
      if (i == s.len() || s.getc(i) == " ") begin
        if (i > st) begin
          string t;
          t = s.substr(st, i - 1);
          if (idx.exists(t)) v |= bitof(t);
        end
        st = i + 1;
      end
    end
    return v;
  endfunction

  function automatic string r3(input string op);
    return {"Grb Rout RYin|Grc Rout ", op,
            " RZin|RZout Gra Rin"};
  endfunction

  function automatic string i3(input string op);
    return {"Grb Rout RYin|Cout ", op, " RZin|RZout Gra Rin"};
  endfunction

  function automatic string exec_of(input int op);
    case (op)
      0:  return {"Grb BAout RYin|Cout ADD RZin|RZout MARin",
                  "|Read MDRin|MDRout Gra Rin"};
      1:  return "Grb BAout RYin|Cout ADD RZin|RZout Gra Rin";
      2:  return {"Grb BAout RYin|Cout ADD RZin|RZout MARin",
                  "|Gra Rout MDRin|Write"};
      3:  return r3("ADD");
      4:  return r3("SUB");
      5:  return r3("SHR");
      6:  return r3("SHL");
      7:  return r3("ROR");
      8:  return r3("ROL");
      9:  return r3("AND");
      10: return r3("OR");
      11: return i3("ADD");
      12: return i3("AND");
      13: return i3("OR");
`ifdef CU_MULDIV_EN
      14: return "Gra Rout RYin|Grb Rout MUL RZin|RZout HILOin";
      15: return "Gra Rout RYin|Grb Rout DIV RZin|RZout HILOin";
`endif
      16: return "Grb Rout NEGATE RZin|RZout Gra Rin";
      17: return "Grb Rout NOT RZin|RZout Gra Rin";
      18: return "Gra Rout CONin|PCout RYin|Cout ADD RZin|RZout";
      19: return "Gra Rout PCin";
      20: return "PCout Grb Rin|Gra Rout PCin";
      21: return "INPUTout Gra Rin";
      22: return "Gra Rout OUTPUTin";
      23, 24: return "HILOout Gra Rin";
      default: return "";
    endcase
  endfunction

  // Runs one instruction from T0, checking every cycle. con_mode<0
  // randomises CON; abort_at>=0 asserts reset after that step.
  task automatic run_instr(input int op, input int con_mode,
                           input int abort_at);
    string full, steps[$];
    logic [36:0] exp;
    int st;
    full = {"PCout MARin IncPC RZin|RZout PCin Read MDRin",
            "|MDRout IRin"};
    if (exec_of(op) != "") full = {full, "|", exec_of(op)};
    st = 0;
    for (int i = 0; i <= full.len(); i++) begin
      if (i == full.len() || full.getc(i) == "|") begin
        steps.push_back(full.substr(st, i - 1));
        st = i + 1;
      end
    end
    IRVal = {op[4:0], 27'($urandom)};
    for (int i = 0; i < steps.size(); i++) begin
      CON = (con_mode < 0) ? 1'($urandom) : 1'(con_mode);
      #1;
      exp = to_vec(steps[i]) | bitof("Run");
      if (op == 18 && i == 6 && CON) exp |= bitof("PCin");
      chk($sformatf("op%0d.step%0d", op, i), act, exp);
      if (i == abort_at) begin
        reset = 1'b0;
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      CON = 1'($urandom);
      #1;
      chk(tag, act, '0);
      @(negedge clk);
    end
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_pulse", act, '0);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int op;
    foreach (nm[i]) idx[nm[i]] = i;
    reset = 1'b0;
    Stop  = 1'b0;
    CON   = 1'b0;
    IRVal = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_hold", act, '0);
    reset = 1'b1;
    @(negedge clk);

    run_instr(3, -1, -1);
    run_instr(18, 0, -1);
    run_instr(18, 1, -1);
    run_instr(2, -1, -1);
    run_instr(0, -1, -1);
    run_instr(25, -1, -1);
    run_instr(19, -1, -1);
    run_instr(20, -1, -1);
    run_instr(14, -1, -1);
    run_instr(15, -1, -1);
    run_instr(27, -1, -1);
    run_instr(31, -1, -1);

    run_instr(0, -1, 5);
    chk("abort_ld_e3", act, '0);
    reset = 1'b1;
    @(negedge clk);
    run_instr(2, -1, 5);
    chk("abort_st_e3", act, '0);
    reset = 1'b1;
    @(negedge clk);

    run_instr(26, -1, -1);
    idle_check("halt_idle", 22);
    reset_pulse();

    Stop = 1'b1;
    run_instr(4, -1, -1);
    Stop = 1'b0;
    idle_check("stop_idle", 20);
    reset_pulse();

    Stop = 1'b1;
    run_instr(25, -1, -1);
    Stop = 1'b0;
    idle_check("stop_nop_idle", 5);
    reset_pulse();

    repeat (300) begin
      op = int'($urandom_range(0, 31));
      if (op == 26) op = 25;
      run_instr(op, -1, -1);
    end

    run_instr(26, -1, -1);
    idle_check("final_halt", 20);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
